// File: rtl/vpu_scanout.sv
// Display scanout for the VPU line buffer: reads one pixel per dot from port A,
// clears it behind the read, and produces registered color, dot_clk, hsync and vsync.
module vpu_scanout #(
    parameter int H_ACTIVE      = 320,
    parameter int H_BLANK       = 80,
    parameter int V_ACTIVE      = 240,
    parameter int V_BLANK       = 22,
    parameter int HSYNC_START   = 336,
    parameter int HSYNC_LEN     = 32,
    parameter int VSYNC_START   = 250,
    parameter int VSYNC_LEN     = 3,
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       line_cycle,
    input  logic [8:0]        y,
    output logic              line_en,
    output logic              line_we,
    output logic [ADDR_W-1:0] line_addr,
    output logic [DATA_W-1:0] line_din,
    input  logic [DATA_W-1:0] line_dout,
    output logic              dot_clk,
    output logic [DATA_W-1:0] color,
    output logic              hsync,
    output logic              vsync
);

    localparam int LINE_CLKS   = 4 * (H_ACTIVE + H_BLANK);
    localparam int FRAME_LINES = V_ACTIVE + V_BLANK;

    if (H_ACTIVE > (1 << ADDR_W)) begin : g_addr_chk
        $error("vpu_scanout: H_ACTIVE does not fit in line_addr");
    end
    if (LINE_CLKS > 2048 || FRAME_LINES > 512) begin : g_timing_chk
        $error("vpu_scanout: line or frame length exceeds line_cycle/y range");
    end

    // Thresholds sized to the 9-bit dot and line indices they are compared with.
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_FIRST = 9'(HSYNC_START);
    localparam logic [8:0] HS_END   = 9'(HSYNC_START + HSYNC_LEN);
    localparam logic [8:0] VS_FIRST = 9'(VSYNC_START);
    localparam logic [8:0] VS_END   = 9'(VSYNC_START + VSYNC_LEN);
    localparam bit         CLEAR    = (CLEAR_ON_READ != 0);

    typedef enum logic [1:0] {
        PH_READ    = 2'd0,
        PH_WAIT    = 2'd1,
        PH_CAPTURE = 2'd2,
        PH_CLEAR   = 2'd3
    } phase_t;

    phase_t            ph;
    logic [8:0]        x;
    logic              active;
    logic              en_d, we_d, dot_clk_d, hsync_d, vsync_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] color_d;

    assign line_din = '0;

    // The phase comes straight from line_cycle, so the scan follows vpu_core with no local counter.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        en_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = line_addr;
        color_d   = color;
        ph        = phase_t'(line_cycle[1:0]);
        x         = line_cycle[10:2];
        active    = (x < H_ACT) && (y < V_ACT);
        dot_clk_d = line_cycle[1];
        hsync_d   = !((x >= HS_FIRST) && (x < HS_END));
        vsync_d   = !((y >= VS_FIRST) && (y < VS_END));

        case (ph)
            PH_READ: begin
                if (active) begin
                    en_d   = 1'b1;
                    addr_d = ADDR_W'(x);
                end
            end
            PH_WAIT: begin
                en_d = 1'b0;
            end
            PH_CAPTURE: begin
                color_d = active ? line_dout : '0;
            end
            PH_CLEAR: begin
                if (active && CLEAR) begin
                    en_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(x);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!rst_n) begin
            line_en   <= 1'b0;
            line_we   <= 1'b0;
            line_addr <= '0;
            color     <= '0;
            dot_clk   <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            line_en   <= en_d;
            line_we   <= we_d;
            line_addr <= addr_d;
            color     <= color_d;
            dot_clk   <= dot_clk_d;
            hsync     <= hsync_d;
            vsync     <= vsync_d;
        end
    end

endmodule

// File: tb/tb_vpu_scanout.sv
// Self-checking bench for vpu_scanout: a behavioural line-buffer memory plus a
// dot/line-level reference model of the scanout timing, driven by directed steps.
module tb_vpu_scanout;

    localparam int HA       = 320;
    localparam int VA       = 240;
    localparam int LINE_CLK = 1600;
    localparam int FRAME_LN = 262;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lc;
    logic [8:0]  yv;
    logic [31:0] line_dout;

    logic        line_en, line_we, dot_clk, hsync, vsync;
    logic [8:0]  line_addr;
    logic [31:0] line_din, color;

    logic        nc_en, nc_we, nc_dot_clk, nc_hsync, nc_vsync;
    logic [8:0]  nc_addr;
    logic [31:0] nc_din, nc_color;

    logic [31:0] mem  [512];
    logic [31:0] gold [512];
    logic [31:0] m_color;

    int checks   = 0;
    int failures = 0;
    int hs_low;
    bit hs_count;

    always #5 clk = ~clk;

    vpu_scanout u_dut (
        .clk(clk), .rst_n(rst_n), .line_cycle(lc), .y(yv),
        .line_en(line_en), .line_we(line_we), .line_addr(line_addr),
        .line_din(line_din), .line_dout(line_dout),
        .dot_clk(dot_clk), .color(color), .hsync(hsync), .vsync(vsync)
    );

    vpu_scanout #(.CLEAR_ON_READ(0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .line_cycle(lc), .y(yv),
        .line_en(nc_en), .line_we(nc_we), .line_addr(nc_addr),
        .line_din(nc_din), .line_dout(32'h0),
        .dot_clk(nc_dot_clk), .color(nc_color), .hsync(nc_hsync), .vsync(nc_vsync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (lc=%0d y=%0d)", tag, obs, exp, lc, yv);
        end
    endtask

    // One clock: predict from the inputs presented now, serve port A like a
    // synchronous RAM, then compare every output just after the edge.
    task automatic tick();
        int   x, ph;
        bit   act;
        logic s_en, s_we;
        logic [8:0]  s_addr;
        logic [31:0] s_din;
        logic e_en, e_we, e_dclk, e_hs, e_vs, e_nc_en;
        int   e_addr;

        s_en   = line_en;
        s_we   = line_we;
        s_addr = line_addr;
        s_din  = line_din;

        x   = int'(lc) / 4;
        ph  = int'(lc) % 4;
        act = (x < HA) && (int'(yv) < VA);

        if (!rst_n) begin
            e_en = 0; e_we = 0; e_dclk = 0; e_hs = 1; e_vs = 1; e_nc_en = 0;
            e_addr  = 0;
            m_color = 32'h0;
        end else begin
            e_en    = act && (ph == 0 || ph == 3);
            e_we    = act && (ph == 3);
            e_nc_en = act && (ph == 0);
            e_dclk  = (ph >= 2);
            e_hs    = !(x >= 336 && x < 368);
            e_vs    = !(int'(yv) >= 250 && int'(yv) < 253);
            e_addr  = x;
            if (ph == 2) m_color = act ? gold[x] : 32'h0;
            if (ph == 3 && act) gold[x] = 32'h0;
        end

        @(posedge clk);
        #1;
        if (s_en) begin
            if (s_we) mem[s_addr] = s_din;
            else      line_dout   = mem[s_addr];
        end

        check("color",   color,   m_color);
        check("hsync",   {31'h0, hsync},   {31'h0, e_hs});
        check("vsync",   {31'h0, vsync},   {31'h0, e_vs});
        check("dot_clk", {31'h0, dot_clk}, {31'h0, e_dclk});
        check("line_en", {31'h0, line_en}, {31'h0, e_en});
        check("line_we", {31'h0, line_we}, {31'h0, e_we});
        if (e_en || !rst_n) check("line_addr", {23'h0, line_addr}, e_addr);
        if (e_we) check("line_din", line_din, 32'h0);
        check("nc_line_we", {31'h0, nc_we}, 32'h0);
        check("nc_line_en", {31'h0, nc_en}, {31'h0, e_nc_en});
        if (hs_count && !hsync) hs_low++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            if (lc == 11'(LINE_CLK - 1)) begin
                lc = 11'd0;
                yv = (yv == 9'(FRAME_LN - 1)) ? 9'd0 : yv + 9'd1;
            end else begin
                lc = lc + 11'd1;
            end
        end
    endtask

    task automatic preload_random();
        for (int i = 0; i < HA; i++) begin
            mem[i]  = $urandom;
            gold[i] = mem[i];
        end
    endtask

    initial begin
        int nz;
        int s;

        rst_n = 1'b0; lc = 11'd0; yv = 9'd0; line_dout = 32'h0;
        m_color = 32'h0; hs_low = 0; hs_count = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 32'h0;
            gold[i] = 32'h0;
        end
        for (int i = 0; i < HA; i++) begin
            mem[i]  = 32'h1000_0000 + 32'(i);
            gold[i] = mem[i];
        end

        // Reset values.
        run(3);
        lc = 11'd0;

        // Line 0 with the ramp pattern, counting hsync-low clocks.
        rst_n = 1'b1;
        hs_count = 1'b1;
        run(LINE_CLK);
        hs_count = 1'b0;
        check("hsync_low_clks", hs_low, 128);

        nz = 0;
        for (int i = 0; i < HA; i++) if (mem[i] != 32'h0) nz++;
        check("cleared_nonzero_addrs", nz, 0);

        // Line 1 with random pixels.
        preload_random();
        run(LINE_CLK);

        // Reset held 5 clk mid-line, released on a ph0 boundary.
        preload_random();
        yv = 9'd5; lc = 11'd0;
        s = 4 * int'($urandom_range(10, 300)) + 3;
        run(s);
        rst_n = 1'b0;
        run(5);
        rst_n = 1'b1;
        run(LINE_CLK - s - 5);

        // Vertical blanking line.
        preload_random();
        yv = 9'd240; lc = 11'd0;
        run(LINE_CLK);

        // Vsync edges: lines around the pulse.
        for (int v = 248; v <= 254; v++) begin
            yv = 9'(v);
            lc = 11'd1592;
            run(8);
        end

        // Frame wrap into line 0.
        preload_random();
        yv = 9'(FRAME_LN - 1); lc = 11'd1592;
        run(8 + 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
